// File: rtl/qos_egress_drain.sv
// -----------------------------------------------------------------------------
// qos_egress_drain
//
// Egress consumer for the four QoS class FIFOs (P0..P3). Selects a class with
// weighted round-robin, pops it, captures the registered read data one cycle
// later into a 2-entry output queue and presents the head on a valid/ready
// stream. Keeps saturating 8-bit per-class and total pop counters, readable
// through a registered req/idx port.
//
// Build option:
//   QOS_STRICT_PRIORITY_EN - when defined, class selection is strict priority
//                            (P0 highest); a zero weight still excludes a class.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   enable       allow new pops
//   fifo_empty   empty flag per class FIFO
//   fifo_data0-3 registered read data per class FIFO (valid the cycle after pop)
//   pop          one-hot pop strobe (combinational)
//   data_out     head word of the output queue
//   valid_out    head word valid
//   ready_in     downstream accepts data_out this cycle
//   req, idx     counter read request / select (0..3 class, 4 total)
//   valid, data  counter read response, one cycle after req
//   idle         nothing in flight, queue empty, all FIFOs empty
// -----------------------------------------------------------------------------
module qos_egress_drain #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned W0         = 4,
    parameter int unsigned W1         = 3,
    parameter int unsigned W2         = 2,
    parameter int unsigned W3         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data0,
    input  logic [DATA_WIDTH-1:0] fifo_data1,
    input  logic [DATA_WIDTH-1:0] fifo_data2,
    input  logic [DATA_WIDTH-1:0] fifo_data3,
    output logic [3:0]            pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    input  logic                  req,
    input  logic [2:0]            idx,
    output logic                  valid,
    output logic [7:0]            data,
    output logic                  idle
);

    function automatic logic [3:0] wgt(input logic [1:0] c);
        logic [3:0] w;
        unique case (c)
            2'd0:    w = 4'(W0);
            2'd1:    w = 4'(W1);
            2'd2:    w = 4'(W2);
            default: w = 4'(W3);
        endcase
        return w;
    endfunction

    // State
    logic [1:0]            grant_q, grant_d;
    logic [3:0]            credit_q, credit_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            pop_cls_q, pop_cls_d;
    logic [DATA_WIDTH-1:0] q_q [2];
    logic [DATA_WIDTH-1:0] q_d [2];
    logic [1:0]            qcount_q, qcount_d;
    logic [7:0]            cnt_q [4];
    logic [7:0]            cnt_d [4];
    logic [7:0]            total_q, total_d;
    logic                  valid_q, valid_d;
    logic [7:0]            data_q, data_d;

    // Combinational
    logic [3:0]            elig;
    logic                  sel_found;
    logic [1:0]            sel_cls;
    logic                  xfer;
    logic [2:0]            occ;
    logic                  pop_any;
    logic [DATA_WIDTH-1:0] cap_data;
`ifndef QOS_STRICT_PRIORITY_EN
    logic [3:0]            eff_credit;
`endif

    assign xfer = valid_out & ready_in;
    // Words queued plus the word in flight, minus the one leaving this edge.
    assign occ  = 3'(qcount_q) + 3'(inflight_q) - 3'(xfer);

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            elig[c] = !fifo_empty[c] && (wgt(2'(c)) != 4'd0);
        end
    end

    // Class selection
    always_comb begin
        sel_found = 1'b0;
        sel_cls   = grant_q;
`ifdef QOS_STRICT_PRIORITY_EN
        for (int c = 3; c >= 0; c--) begin
            if (elig[c]) begin
                sel_found = 1'b1;
                sel_cls   = 2'(c);
            end
        end
`else
        eff_credit = credit_q;
        if (elig[grant_q] && credit_q != 4'd0) begin
            sel_found = 1'b1;
        end else begin
            // k = 4 wraps back to grant itself with a fresh credit.
            for (int k = 1; k <= 4; k++) begin
                if (!sel_found && elig[grant_q + 2'(k)]) begin
                    sel_found  = 1'b1;
                    sel_cls    = grant_q + 2'(k);
                    eff_credit = wgt(grant_q + 2'(k));
                end
            end
        end
`endif
    end

    assign pop_any = enable && sel_found && (occ < 3'd2);
    assign pop     = pop_any ? (4'b0001 << sel_cls) : 4'b0000;

    // WRR state and in-flight tracking
    always_comb begin
        grant_d    = grant_q;
        credit_d   = credit_q;
        inflight_d = pop_any;
        pop_cls_d  = pop_cls_q;
        if (pop_any) begin
            pop_cls_d = sel_cls;
`ifndef QOS_STRICT_PRIORITY_EN
            if (eff_credit == 4'd1) begin
                grant_d  = sel_cls + 2'd1;
                credit_d = wgt(sel_cls + 2'd1);
            end else begin
                grant_d  = sel_cls;
                credit_d = eff_credit - 4'd1;
            end
`endif
        end
    end

    always_comb begin
        unique case (pop_cls_q)
            2'd0:    cap_data = fifo_data0;
            2'd1:    cap_data = fifo_data1;
            2'd2:    cap_data = fifo_data2;
            default: cap_data = fifo_data3;
        endcase
    end

    // Output queue: slot 0 is the head; transfer shifts, capture appends.
    always_comb begin
        q_d[0]   = q_q[0];
        q_d[1]   = q_q[1];
        qcount_d = qcount_q;
        if (xfer) begin
            q_d[0]   = q_q[1];
            qcount_d = qcount_q - 2'd1;
        end
        if (inflight_q) begin
            if (qcount_d == 2'd0) begin
                q_d[0] = cap_data;
            end else begin
                q_d[1] = cap_data;
            end
            qcount_d = qcount_d + 2'd1;
        end
    end

    assign data_out  = q_q[0];
    assign valid_out = (qcount_q != 2'd0);
    assign idle      = !inflight_q && (qcount_q == 2'd0) && (&fifo_empty);

    // Saturating pop counters
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cnt_d[c] = cnt_q[c];
            if (pop[c] && cnt_q[c] != 8'hFF) begin
                cnt_d[c] = cnt_q[c] + 8'd1;
            end
        end
        total_d = total_q;
        if (pop_any && total_q != 8'hFF) begin
            total_d = total_q + 8'd1;
        end
    end

    // Counter read port
    always_comb begin
        valid_d = req;
        data_d  = 8'd0;
        if (req) begin
            unique case (idx)
                3'd0:    data_d = cnt_q[0];
                3'd1:    data_d = cnt_q[1];
                3'd2:    data_d = cnt_q[2];
                3'd3:    data_d = cnt_q[3];
                3'd4:    data_d = total_q;
                default: data_d = 8'd0;
            endcase
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q    <= 2'd0;
            credit_q   <= 4'(W0);
            inflight_q <= 1'b0;
            pop_cls_q  <= 2'd0;
            q_q[0]     <= '0;
            q_q[1]     <= '0;
            qcount_q   <= 2'd0;
            for (int c = 0; c < 4; c++) begin
                cnt_q[c] <= 8'd0;
            end
            total_q    <= 8'd0;
            valid_q    <= 1'b0;
            data_q     <= 8'd0;
        end else begin
            grant_q    <= grant_d;
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            pop_cls_q  <= pop_cls_d;
            q_q[0]     <= q_d[0];
            q_q[1]     <= q_d[1];
            qcount_q   <= qcount_d;
            for (int c = 0; c < 4; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            total_q    <= total_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_qos_egress_drain.sv
// -----------------------------------------------------------------------------
// Directed bench for qos_egress_drain. Four simple class FIFO models with
// registered read data feed the DUT; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_qos_egress_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ready_in;
    logic        req;
    logic [2:0]  idx;
    logic [3:0]  fifo_empty;
    logic [11:0] fdata [4];
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic        valid;
    logic [7:0]  data;
    logic        idle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    qos_egress_drain dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data0 (fdata[0]),
        .fifo_data1 (fdata[1]),
        .fifo_data2 (fdata[2]),
        .fifo_data3 (fdata[3]),
        .pop        (pop),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .req        (req),
        .idx        (idx),
        .valid      (valid),
        .data       (data),
        .idle       (idle)
    );

    // Class FIFO models: pop sampled mid-cycle, read data registered.
    logic [11:0] mem [4][64];
    logic [5:0]  rd_ptr [4] = '{default: '0};
    logic [5:0]  wr_ptr [4] = '{default: '0};
    logic [3:0]  pop_s = 4'd0;

    always_comb begin
        for (int i = 0; i < 4; i++) fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
    end

    always @(negedge clk) pop_s <= pop;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i]) begin
                fdata[i]  <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 6'd1;
            end
        end
    end

    // Monitor: pops issued and words delivered.
    int          mon_pops = 0;
    int          mon_nw = 0;
    logic [11:0] mon_words [256];

    always @(negedge clk) begin
        mon_pops <= mon_pops + $countones(pop);
        if (valid_out && ready_in) begin
            mon_words[mon_nw] <= data_out;
            mon_nw <= mon_nw + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic load_word(input int c, input logic [11:0] w);
        mem[c][wr_ptr[c]] = w;
        wr_ptr[c] = wr_ptr[c] + 6'd1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        ready_in = 1'b0;
        req = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < 4; i++) wr_ptr[i] = rd_ptr[i];
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic read_cnt(input string tag, input logic [2:0] k, input logic [7:0] exp);
        req = 1'b1;
        idx = k;
        step();
        req = 1'b0;
        sample();
        check_eq({tag, "_valid"}, 32'(valid), 32'd1);
        check_eq(tag, 32'(data), 32'(exp));
    endtask

    logic [11:0] sw [4]   = '{12'h0FF, 12'h504, 12'hA95, 12'hFAE};
    int          seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    logic [7:0]  cexp [6] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd10, 8'd0};
    logic [11:0] exp_w [10];
    logic [11:0] bp_w [5] = '{12'h1A1, 12'h1B2, 12'h1C3, 12'h1D4, 12'h1E5};
    logic [11:0] ed_w [2] = '{12'h2C7, 12'h2D8};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kc [4];
        int base_p;
        int base_n;

        // ---------------- reset ----------------
        reset = 1'b0;
        enable = 1'b0;
        ready_in = 1'b0;
        req = 1'b0;
        idx = 3'd0;
        step();
        sample();
        check_eq("rst_pop", 32'(pop), 32'd0);
        check_eq("rst_vout", 32'(valid_out), 32'd0);
        check_eq("rst_dout", 32'(data_out), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_idle", 32'(idle), 32'd1);
        step();
        reset = 1'b1;
        sample();
        check_eq("rel_pop", 32'(pop), 32'd0);
        check_eq("rel_vout", 32'(valid_out), 32'd0);
        check_eq("rel_idle", 32'(idle), 32'd1);
        step();
        for (int k = 0; k < 5; k++) read_cnt("rel_cnt", 3'(k), 8'd0);

        // ---------------- single class ----------------
        do_reset();
        for (int k = 0; k < 4; k++) load_word(0, sw[k]);
        enable = 1'b1;
        ready_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            check_eq("sc_pop", 32'(pop), (c < 4) ? 32'd1 : 32'd0);
            check_eq("sc_vout", 32'(valid_out), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5) check_eq("sc_dout", 32'(data_out), 32'(sw[c-2]));
            step();
        end
        sample();
        check_eq("sc_idle", 32'(idle), 32'd1);
        enable = 1'b0;
        step();
        read_cnt("sc_cnt0", 3'd0, 8'd4);
        read_cnt("sc_total", 3'd4, 8'd4);

        // ---------------- WRR weights ----------------
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 10; k++) load_word(c, 12'(c * 256 + k));
            kc[c] = 0;
        end
        for (int i = 0; i < 10; i++) begin
            exp_w[i] = 12'(seq[i] * 256 + kc[seq[i]]);
            kc[seq[i]]++;
        end
        enable = 1'b1;
        ready_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 10) enable = 1'b0;
            sample();
            check_eq("wrr_pop", 32'(pop), (c < 10) ? (32'd1 << seq[c]) : 32'd0);
            if (c >= 2) begin
                check_eq("wrr_vout", 32'(valid_out), 32'd1);
                check_eq("wrr_dout", 32'(data_out), 32'(exp_w[c-2]));
            end
            step();
        end
        step();

        // ---------------- counter port ----------------
        req = 1'b1;
        idx = 3'd0;
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) idx = 3'(k);
            else req = 1'b0;
            sample();
            check_eq("cp_valid", 32'(valid), 32'd1);
            check_eq("cp_data", 32'(data), 32'(cexp[k-1]));
            step();
        end
        sample();
        check_eq("cp_valid_off", 32'(valid), 32'd0);
        check_eq("cp_data_off", 32'(data), 32'd0);
        step();

        // ---------------- backpressure ----------------
        do_reset();
        for (int k = 0; k < 5; k++) load_word(1, bp_w[k]);
        base_p = mon_pops;
        base_n = mon_nw;
        enable = 1'b1;
        ready_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            check_eq("bp_pop", 32'(pop), (c < 2) ? 32'h2 : 32'd0);
            if (c >= 2) begin
                check_eq("bp_vout", 32'(valid_out), 32'd1);
                check_eq("bp_hold", 32'(data_out), 32'(bp_w[0]));
            end
            step();
        end
        ready_in = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if ((mon_nw - base_n) >= 5 && idle) break;
            step();
        end
        check_eq("bp_nwords", 32'(mon_nw - base_n), 32'd5);
        check_eq("bp_npops", 32'(mon_pops - base_p), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_word", 32'(mon_words[base_n + k]), 32'(bp_w[k]));
        end
        enable = 1'b0;
        step();
        read_cnt("bp_cnt1", 3'd1, 8'd5);

        // ---------------- enable drop ----------------
        do_reset();
        load_word(2, ed_w[0]);
        load_word(2, ed_w[1]);
        enable = 1'b1;
        ready_in = 1'b0;
        sample();
        check_eq("ed_pop0", 32'(pop), 32'h4);
        step();
        enable = 1'b0;
        sample();
        check_eq("ed_pop1", 32'(pop), 32'd0);
        check_eq("ed_idle1", 32'(idle), 32'd0);
        step();
        for (int c = 2; c < 4; c++) begin
            sample();
            check_eq("ed_vout", 32'(valid_out), 32'd1);
            check_eq("ed_dout", 32'(data_out), 32'(ed_w[0]));
            check_eq("ed_idle", 32'(idle), 32'd0);
            check_eq("ed_pop", 32'(pop), 32'd0);
            step();
        end
        ready_in = 1'b1;
        sample();
        check_eq("ed_vout_acc", 32'(valid_out), 32'd1);
        step();
        ready_in = 1'b0;
        sample();
        check_eq("ed_vout_done", 32'(valid_out), 32'd0);
        check_eq("ed_pop_done", 32'(pop), 32'd0);
        check_eq("ed_idle_done", 32'(idle), 32'd0);
        step();
        read_cnt("ed_total", 3'd4, 8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
